cbus_mem_responder: RTL
=======================

// Module: cbus_mem_responder
// PURPOSE
//  Responder (slave) end of the cached-bus (cbus) protocol: accepts cbus_req_t from the arbiter's oreq
//  and returns cbus_resp_t. It models a word-addressed, byte-writable RAM with a programmable
//  first-beat latency. It is the memory target for core/cache/arbiter simulation and the reference
//  responder for protocol checks. It serves single beats and incremental bursts (MLEN1..MLEN16).
// PARAMETERS
//  ADDR_WIDTH  10  word-index bits; RAM holds 2**ADDR_WIDTH 32-bit words
//  LATENCY     2   idle cycles between request capture and the first ready beat (0..15)
// PORTS
//  clk     in   1    single clock; every register updates on its rising edge
//  reset   in   1    asynchronous, active-high reset
//  creq    in   cbus_req_t   valid, is_write, size, addr[31:0], strobe[3:0], data[31:0], len (mlen_t)
//  cresp   out  cbus_resp_t  ready (beat transfers this cycle), last (final beat), data[31:0]
//  err     out  1    sticky protocol-error flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, beat=0, wcnt=0, err=0. Outputs cresp.ready=0, cresp.last=0, cresp.data=0.
//   RAM contents are NOT cleared. Reset asserted mid-burst aborts the burst at once.
//  FSM IDLE -> WAIT -> BURST -> IDLE:
//   IDLE : if creq.valid, capture base=addr[ADDR_WIDTH+1:2], nbeat=len (0..15), wr=is_write, beat=0.
//          Go to WAIT with wcnt=LATENCY-1, or to BURST directly when LATENCY==0.
//   WAIT : decrement wcnt; go to BURST when wcnt==0. ready=0.
//   BURST: ready=1 every cycle. last=(beat==nbeat). beat increments per cycle.
//          After the last beat, go to IDLE.
//  Latency: valid sampled at edge T gives the first ready in cycle T+1+LATENCY.
//   An N-beat burst then holds ready for N consecutive cycles. There are no bubbles inside a burst.
//  Beat address: idx=(base+beat) mod 2**ADDR_WIDTH, so the index wraps silently at the top of the RAM.
//  Read: cresp.data=mem[idx], combinational from registered state, valid while ready=1.
//   When ready=0, or during a write, cresp.data=0.
//  Write: at each BURST edge with wr=1, for each byte b with creq.strobe[b]=1,
//   mem[idx][8b+7:8b] <= creq.data[8b+7:8b]. The write uses the live beat data and strobe.
//   strobe=0 writes nothing but still consumes the beat.
//  size: unused for data path; reads always return the full word. size is checked only for err.
//  IDLE after last: valid is sampled afresh, so a new request is captured at the edge after
//   the last beat. Back-to-back requests (e.g. arbiter switching masters) are legal.
//  Boundary / violation cases (each sets err=1):
//   - creq.valid drops during WAIT or BURST: abort to IDLE. No further writes.
//   - addr[1:0]!=0 with len!=MLEN1: served from the word-aligned address.
//   - is_write/addr/len change mid-transaction: ignored. The captured values rule until last.
//  Simultaneous last beat and reset: reset wins. That beat's write may or may not land;
//   the bench must not check it.
// STRUCTURE
//  Shared package cbus_resp_pkg: resp_state_t enum {IDLE,WAIT,BURST}; function mlen_beats(mlen_t)
//   returning 1..16. The cbus_req_t/cbus_resp_t/mlen_t types stay in the existing access header.
//  Sub-module cbus_mem_array: 2**ADDR_WIDTH x 32 RAM with an async read port and a byte-strobed
//   synchronous write port. The top module holds only the FSM, counters and err.
// TESTING
//  1 LATENCY=2, 4 writes then MLEN1 read of word 0x10 holding 0xDEADBEEF, valid at T:
//    ready=last=1 in T+3 only, data=0xDEADBEEF.
//  2 MLEN16 read at addr 0x100, mem[0x40+i]=i: ready high T+3..T+18, data 0..15 in order,
//    last only in T+18.
//  3 MLEN1 write addr 0x20, data 0x11223344, strobe 4'b0101 over old 0xAABBCCDD:
//    readback 0xAA22CC44. err stays 0.
//  4 MLEN4 write immediately followed by MLEN4 read of the same line: read returns the written
//    words. The second request is captured at the edge after the write's last beat.
//  5 reset high in the 3rd beat of MLEN8 read: ready/last/data=0 at once. IDLE after release.
//    A fresh MLEN1 read completes normally.
//  6 valid dropped after 2 beats of MLEN8: FSM returns to IDLE, err=1 and stays 1.
//    Also misaligned addr 0x102 with MLEN4 serves words 0x40..0x43 and sets err.
//    Rerun tests 1-2 with LATENCY=0: first ready at T+1.

Source files
------------

// File: rtl/cbus_pkg.sv
// Cached-bus (cbus) access types shared by requesters, the arbiter and responders.
//   mlen_t      : burst length code, MLEN1 (one beat) .. MLEN16 (sixteen beats)
//   msize_t     : access size code; MSIZE4 is a full 32-bit word
//   cbus_req_t  : valid, is_write, size, addr, strobe, data, len
//   cbus_resp_t : ready (beat transfers this cycle), last (final beat), data
package cbus_pkg;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
    MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
    MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
    MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_resp_pkg.sv
// Responder-side definitions for cbus memory targets.
//   resp_state_t : responder FSM states
//   mlen_beats   : number of beats (1..16) encoded by an mlen_t
package cbus_resp_pkg;
  import cbus_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } resp_state_t;

  function automatic int unsigned mlen_beats(mlen_t len);
    return {28'd0, len} + 32'd1;
  endfunction

endpackage

// File: rtl/cbus_mem_array.sv
// Word-addressed RAM, 2**ADDR_WIDTH x 32 bits, no reset on contents.
//   clk_i   : write clock
//   addr_i  : word index shared by the read and write ports
//   wstrb_i : per-byte write enables, sampled on the rising edge
//   wdata_i : write data
//   rdata_o : asynchronous read of mem[addr_i]
module cbus_mem_array #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            wstrb_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wstrb_i[b]) begin
        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/cbus_mem_responder.sv
// cbus responder backed by a byte-writable RAM with programmable first-beat latency.
// Serves single beats and incremental bursts (MLEN1..MLEN16).
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   creq  : request from the arbiter; must hold valid and fields until the last beat
//   cresp : ready/last per beat, read data (zero when idle or writing)
//   err   : sticky protocol-error flag, cleared only by reset
module cbus_mem_responder
  import cbus_pkg::*;
  import cbus_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       err
);

  // WAIT counts down from LATENCY-1 to 0, giving exactly LATENCY idle cycles.
  localparam logic [3:0] WaitInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  resp_state_t state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  mlen_t       nbeat_q, nbeat_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;

  logic                  last;
  logic                  field_change;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            wstrb;
  logic [31:0]           rdata;

  assign last = ({1'b0, beat_q} + 5'd1) == 5'(mlen_beats(nbeat_q));

  // Captured fields rule the transaction; any live change is only flagged.
  assign field_change = (creq.is_write != wr_q) || (creq.addr != addr_q) ||
                        (creq.len != nbeat_q);

  // Low address bits are dropped, so misaligned bursts are served word-aligned.
  assign idx = addr_q[ADDR_WIDTH+1:2] + ADDR_WIDTH'(beat_q);

  // A beat with valid already dropped is being aborted and must not write.
  assign wstrb = (state_q == BURST && wr_q && creq.valid) ? creq.strobe : 4'b0000;

  cbus_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clk),
    .addr_i (idx),
    .wstrb_i(wstrb),
    .wdata_i(creq.data),
    .rdata_o(rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      nbeat_q <= MLEN1;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      nbeat_q <= nbeat_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    nbeat_d = nbeat_q;
    wr_d    = wr_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (creq.valid) begin
          addr_d  = creq.addr;
          nbeat_d = creq.len;
          wr_d    = creq.is_write;
          beat_d  = '0;
          if (creq.addr[1:0] != 2'b00 && creq.len != MLEN1) err_d = 1'b1;
          // Wider than the 32-bit data path.
          if (creq.size == MSIZE8) err_d = 1'b1;
          if (LATENCY == 0) begin
            state_d = BURST;
          end else begin
            state_d = WAIT;
            wcnt_d  = WaitInit;
          end
        end
      end
      WAIT: begin
        if (!creq.valid) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          if (field_change) err_d = 1'b1;
          if (wcnt_q == 4'd0) state_d = BURST;
          else                wcnt_d  = wcnt_q - 4'd1;
        end
      end
      BURST: begin
        if (!creq.valid) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          if (field_change) err_d = 1'b1;
          beat_d = beat_q + 4'd1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cresp = '0;
    if (state_q == BURST) begin
      cresp.ready = 1'b1;
      cresp.last  = last;
      if (!wr_q) cresp.data = rdata;
    end
  end

  assign err = err_q;

endmodule
